lcd_capture: RTL
================

Name: lcd_capture

Overview:
- Receive-side counterpart of the LCD timing driver: samples a parallel RGB LCD stream (HS/VS/DE + 24-bit RGB) on the pixel clock.
- Repacks each active pixel to RGB565 and writes it into the frame buffer through a valid/ready write port, with linear address generation.
- Checks line/frame geometry and absorbs short write-side stalls in a small FIFO.
- Used for loopback verification of the display path and for capturing external panels/sources into RAM.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 480, active lines per frame
ADDR_W, 19, write-address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)
FIFO_DEPTH, 4, write FIFO entries (power of two, >=2)

Ports:
lcd_clk  in  1  pixel clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
lcd_hs  in  1  horizontal sync, active-low; informational only, no function
lcd_vs  in  1  vertical sync, active-low
lcd_de  in  1  data enable, active-high
lcd_rgb  in  24  {R[7:0],G[7:0],B[7:0]}
ram_wr_valid  out  1  FIFO head valid
ram_wr_ready  in  1  RAM accepts head when valid&&ready
ram_wr_addr  out  ADDR_W  pixel address of head
ram_wr_data  out  16  RGB565 of head
frame_start  out  1  1-cycle pulse at each detected VS falling edge
frame_done  out  1  1-cycle pulse: previous frame completed with exactly V_ACTIVE lines
line_err  out  1  1-cycle pulse: line ended with pixel count != H_ACTIVE
frame_err  out  1  1-cycle pulse: frame ended with line count != V_ACTIVE
fifo_ovf  out  1  sticky; a pixel was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, counters 0, state IDLE.
- Input stage: lcd_vs/lcd_de/lcd_rgb are registered once. Edges are detected between the registered value and its one-cycle-delayed copy.
- VS falling edge handling:
  - frame_start pulses.
  - x, y, line_base and address reset to 0.
  - In CAPTURE state only: frame_done pulses if y==V_ACTIVE, otherwise frame_err pulses.
  - State goes to CAPTURE.
- States:
  - IDLE: ignore DE; only transition is VS falling edge -> CAPTURE.
  - CAPTURE: remains in CAPTURE; only rst leaves it.
- Pixel accept (CAPTURE, registered DE=1):
  - If x<H_ACTIVE and y<V_ACTIVE: push {addr, RGB565} and increment x and addr.
  - Otherwise: drop the pixel silently; x still increments, saturating at 2^11-1.
- RGB565 packing: {R[7:3], G[7:2], B[7:3]}.
- DE falling edge (CAPTURE):
  - line_err pulses if x!=H_ACTIVE.
  - y increments, saturating.
  - line_base += H_ACTIVE; addr <= new line_base; x <= 0.
  - Short lines therefore never shift later lines.
- Simultaneous DE fall and VS fall in the same cycle: process the line end first, then the VS frame check uses the updated y.
- Latency: a pixel on lcd_rgb at edge N appears on ram_wr_* at edge N+2 when the FIFO is empty (input register + FIFO write).
- FIFO: first-word-fallthrough.
  - Push and pop in the same cycle are allowed when full.
  - Push while full without a simultaneous pop: drop the pixel and set fifo_ovf. fifo_ovf clears only on rst.
  - ram_wr_addr/ram_wr_data must hold stable while valid&&!ready.
- Mid-frame rst: FIFO contents are discarded, no partial writes are emitted, and the block returns to IDLE.

Decomposition:
- Shared package (lcd_pkg): H/V active constants, RGB565 width, rgb888_to_565 function. The LCD driver's RGB565-to-888 expansion also lives in lcd_pkg so both directions share one definition.
- One sub-module: lcd_capture_fifo, a synchronous FWFT FIFO parameterised by width and FIFO_DEPTH, with full/empty outputs.

Test Plan:
1. rst pulse, then 2 full 800x480 frames in standard timing (1056x525 totals) with ram_wr_ready=1 -> exactly 384000 writes per frame, addr 0..383999 ascending, one frame_done after frame 1, no line_err/frame_err, fifo_ovf=0.
2. Single pixel lcd_rgb=24'hFF8040 at x=0,y=0 -> ram_wr_data=16'hFC08, ram_wr_addr=0, valid exactly 2 cycles after the input edge.
3. DE toggling 800 pixels before any VS falling edge -> zero writes and no pulses. After the first VS edge, frame_start=1 for one cycle and the next line starts at addr 0.
4. Line 0 with 799 pixels, then a normal line 1 -> line_err pulses once; line 1's first write goes to addr 800. Frame of 479 lines -> frame_err pulses and frame_done does not.
5. ram_wr_ready held low for 10 cycles mid-line -> 4 entries held with stable addr/data, later pixels dropped, fifo_ovf=1 and sticky. After ready returns, the held entries drain in order.
6. rst asserted at pixel (400,200) with a non-empty FIFO -> ram_wr_valid=0 immediately (async). No writes until the next VS falling edge, then capture restarts at addr 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions for the display driver and the capture path:
// default geometry, pixel widths and RGB888<->RGB565 conversions.
package lcd_pkg;

    localparam int LCD_H_ACTIVE   = 800;
    localparam int LCD_V_ACTIVE   = 480;
    localparam int LCD_ADDR_W     = 19;
    localparam int LCD_FIFO_DEPTH = 4;
    localparam int LCD_CNT_W      = 11;
    localparam int RGB888_W       = 24;
    localparam int RGB565_W       = 16;

    typedef enum logic [0:0] {
        CAP_IDLE    = 1'b0,
        CAP_CAPTURE = 1'b1
    } cap_state_e;

    function automatic logic [RGB565_W-1:0] rgb888_to_565(input logic [RGB888_W-1:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    // Expansion replicates the top bits so full-scale 565 maps to full-scale 888.
    function automatic logic [RGB888_W-1:0] rgb565_to_888(input logic [RGB565_W-1:0] pix);
        return {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
    endfunction

endpackage

// File: rtl/lcd_capture_if.sv
// Frame-buffer write port: valid/ready handshake carrying a pixel address and RGB565 data.
interface lcd_capture_if
    import lcd_pkg::*;
#(
    parameter int ADDR_W = LCD_ADDR_W
);

    logic                ram_wr_valid;
    logic                ram_wr_ready;
    logic [ADDR_W-1:0]   ram_wr_addr;
    logic [RGB565_W-1:0] ram_wr_data;

    modport master (
        output ram_wr_valid,
        output ram_wr_addr,
        output ram_wr_data,
        input  ram_wr_ready
    );

    modport slave (
        input  ram_wr_valid,
        input  ram_wr_addr,
        input  ram_wr_data,
        output ram_wr_ready
    );

endinterface

// File: rtl/lcd_capture_fifo.sv
// Synchronous first-word-fallthrough FIFO; the head entry is visible while empty is low
// and stays unchanged until it is popped.
module lcd_capture_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == (PTR_W + 1)'(0));
    assign do_pop_s  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push_s = push && (!full || do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= (PTR_W + 1)'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + (PTR_W + 1)'(do_push_s) - (PTR_W + 1)'(do_pop_s);
        end
    end

endmodule

// File: rtl/lcd_capture.sv
// Samples a parallel RGB LCD stream, repacks active pixels to RGB565 and writes them to a
// frame buffer with linear addressing, flagging malformed lines and frames.
module lcd_capture
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE   = LCD_H_ACTIVE,
    parameter int V_ACTIVE   = LCD_V_ACTIVE,
    parameter int ADDR_W     = LCD_ADDR_W,
    parameter int FIFO_DEPTH = LCD_FIFO_DEPTH
) (
    input  logic                lcd_clk,
    input  logic                rst,
    input  logic                lcd_hs,
    input  logic                lcd_vs,
    input  logic                lcd_de,
    input  logic [RGB888_W-1:0] lcd_rgb,
    lcd_capture_if.master       wr,
    output logic                frame_start,
    output logic                frame_done,
    output logic                line_err,
    output logic                frame_err,
    output logic                fifo_ovf
);

    localparam int ENTRY_W = ADDR_W + RGB565_W;
    localparam logic [LCD_CNT_W-1:0] CNT_MAX = {LCD_CNT_W{1'b1}};
    localparam logic [LCD_CNT_W-1:0] H_CNT   = LCD_CNT_W'(H_ACTIVE);
    localparam logic [LCD_CNT_W-1:0] V_CNT   = LCD_CNT_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0]    H_STEP  = ADDR_W'(H_ACTIVE);

    logic                 hs_unused;
    logic                 vs_r;
    logic                 vs_d_r;
    logic                 de_r;
    logic                 de_d_r;
    logic [RGB565_W-1:0]  pix_r;
    logic                 vs_fall_s;
    logic                 de_fall_s;
    cap_state_e           state_r;
    cap_state_e           state_s;
    logic [LCD_CNT_W-1:0] x_r;
    logic [LCD_CNT_W-1:0] x_s;
    logic [LCD_CNT_W-1:0] y_r;
    logic [LCD_CNT_W-1:0] y_s;
    logic [ADDR_W-1:0]    base_r;
    logic [ADDR_W-1:0]    base_s;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W-1:0]    addr_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 frame_start_s;
    logic                 frame_done_s;
    logic                 line_err_s;
    logic                 frame_err_s;
    logic                 frame_start_r;
    logic                 frame_done_r;
    logic                 line_err_r;
    logic                 frame_err_r;
    logic                 ovf_r;

    // HSYNC carries no information for capture; geometry comes from DE and VS.
    assign hs_unused = lcd_hs;

    assign vs_fall_s = vs_d_r && !vs_r;
    assign de_fall_s = de_d_r && !de_r;

    // Input register stage plus the delayed copies used for edge detection.
    always_ff @(posedge lcd_clk or posedge rst) begin
        if (rst) begin
            vs_r   <= 1'b0;
            vs_d_r <= 1'b0;
            de_r   <= 1'b0;
            de_d_r <= 1'b0;
            pix_r  <= RGB565_W'(0);
        end else begin
            vs_r   <= lcd_vs;
            vs_d_r <= vs_r;
            de_r   <= lcd_de;
            de_d_r <= de_r;
            pix_r  <= rgb888_to_565(lcd_rgb);
        end
    end

    // Capture state register.
    always_ff @(posedge lcd_clk or posedge rst) begin
        if (rst) begin
            state_r <= CAP_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, counters, FIFO push and status pulses. A line end is applied before a
    // coincident VS edge so the frame check sees the final line count.
    always_comb begin
        state_s       = state_r;
        x_s           = x_r;
        y_s           = y_r;
        base_s        = base_r;
        addr_s        = addr_r;
        push_s        = 1'b0;
        line_err_s    = 1'b0;
        frame_start_s = 1'b0;
        frame_done_s  = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            CAP_CAPTURE: begin
                if (de_r) begin
                    if ((x_r < H_CNT) && (y_r < V_CNT)) begin
                        push_s = 1'b1;
                        addr_s = addr_r + ADDR_W'(1);
                    end else begin
                        push_s = 1'b0;
                    end
                    x_s = (x_r == CNT_MAX) ? x_r : x_r + LCD_CNT_W'(1);
                end else if (de_fall_s) begin
                    line_err_s = (x_r != H_CNT);
                    y_s        = (y_r == CNT_MAX) ? y_r : y_r + LCD_CNT_W'(1);
                    // Lines advance by a fixed stride so a short line cannot shift later ones.
                    base_s     = base_r + H_STEP;
                    addr_s     = base_r + H_STEP;
                    x_s        = LCD_CNT_W'(0);
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                state_s = CAP_IDLE;
            end
        endcase
        if (vs_fall_s) begin
            frame_start_s = 1'b1;
            if (state_r == CAP_CAPTURE) begin
                frame_done_s = (y_s == V_CNT);
                frame_err_s  = (y_s != V_CNT);
            end else begin
                frame_done_s = 1'b0;
            end
            x_s     = LCD_CNT_W'(0);
            y_s     = LCD_CNT_W'(0);
            base_s  = ADDR_W'(0);
            addr_s  = ADDR_W'(0);
            state_s = CAP_CAPTURE;
        end else begin
            frame_start_s = 1'b0;
        end
    end

    // Position counters and address generator.
    always_ff @(posedge lcd_clk or posedge rst) begin
        if (rst) begin
            x_r    <= LCD_CNT_W'(0);
            y_r    <= LCD_CNT_W'(0);
            base_r <= ADDR_W'(0);
            addr_r <= ADDR_W'(0);
        end else begin
            x_r    <= x_s;
            y_r    <= y_s;
            base_r <= base_s;
            addr_r <= addr_s;
        end
    end

    assign pop_s = !empty_s && wr.ram_wr_ready;

    // Registered status pulses and the sticky overflow flag.
    always_ff @(posedge lcd_clk or posedge rst) begin
        if (rst) begin
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            line_err_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            frame_start_r <= frame_start_s;
            frame_done_r  <= frame_done_s;
            line_err_r    <= line_err_s;
            frame_err_r   <= frame_err_s;
            ovf_r         <= ovf_r | (push_s & full_s & ~pop_s);
        end
    end

    lcd_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (lcd_clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data ({addr_r, pix_r}),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign wr.ram_wr_valid = !empty_s;
    assign wr.ram_wr_addr  = head_s[ENTRY_W-1:RGB565_W];
    assign wr.ram_wr_data  = head_s[RGB565_W-1:0];

    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;
    assign line_err    = line_err_r;
    assign frame_err   = frame_err_r;
    assign fifo_ovf    = ovf_r;

endmodule
